// File: rtl/io_sw_debounce.sv
// Switch-bank conditioner: 2-flop sync, per-bit tick-sampled debounce, sticky edge mask.
// Latency: 2 sync cycles + tick alignment + (STABLE_SAMPLES-1)*TICK_DIV; no backpressure.
module io_sw_debounce #(
   parameter int WIDTH          = 32,
   parameter int TICK_DIV       = 50000,
   parameter int STABLE_SAMPLES = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_sw_raw,
   input  logic             i_ack,
   output logic [WIDTH-1:0] o_io_sw,
   output logic             o_sw_changed,
   output logic [WIDTH-1:0] o_edge_mask
);

   localparam int CNT_W  = $clog2(STABLE_SAMPLES + 1);
   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(STABLE_SAMPLES - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   logic [WIDTH-1:0]  sync1;
   logic [WIDTH-1:0]  sync2;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic [CNT_W-1:0]  cnt     [WIDTH];
   logic [CNT_W-1:0]  cnt_nxt [WIDTH];
   logic [WIDTH-1:0]  flip;

   assign tick = (tick_cnt == TICK_LAST);

   // A matching sample restarts the count; the STABLE_SAMPLES-th differing sample toggles.
   always_comb begin
      flip    = '0;
      cnt_nxt = cnt;
      if (tick) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == o_io_sw[i]) begin
               cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
               flip[i]    = 1'b1;
               cnt_nxt[i] = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1        <= '0;
         sync2        <= '0;
         tick_cnt     <= '0;
         o_io_sw      <= '0;
         o_sw_changed <= 1'b0;
         o_edge_mask  <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1        <= i_sw_raw;
         sync2        <= sync1;
         tick_cnt     <= tick ? '0 : tick_cnt + TICK_W'(1);
         o_io_sw      <= o_io_sw ^ flip;
         o_sw_changed <= |flip;
         // A flip landing on the ack edge survives the clear.
         o_edge_mask  <= (i_ack ? '0 : o_edge_mask) | flip;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with TICK_DIV=4, STABLE_SAMPLES=3.
module tb_io_sw_debounce;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_sw_raw;
   logic        i_ack;
   logic [31:0] o_io_sw;
   logic        o_sw_changed;
   logic [31:0] o_edge_mask;

   int nerr = 0;
   int nchk = 0;

   io_sw_debounce #(
      .WIDTH          (32),
      .TICK_DIV       (4),
      .STABLE_SAMPLES (3)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_sw_raw     (i_sw_raw),
      .i_ack        (i_ack),
      .o_io_sw      (o_io_sw),
      .o_sw_changed (o_sw_changed),
      .o_edge_mask  (o_edge_mask)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   typedef struct {
      bit          rst;
      logic [31:0] raw;
      bit          ack;
      int          edges;
      logic [31:0] e_io;
      bit          e_chg;
      logic [31:0] e_mask;
      int          e_pulses;
      string       name;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(bit rst, logic [31:0] raw, bit ack, int edges,
                               logic [31:0] e_io, bit e_chg, logic [31:0] e_mask,
                               int e_pulses, string name);
      vec_t v;
      v.rst = rst; v.raw = raw; v.ack = ack; v.edges = edges;
      v.e_io = e_io; v.e_chg = e_chg; v.e_mask = e_mask;
      v.e_pulses = e_pulses; v.name = name;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_zero_outputs(string tag);
      check({tag, "_io"},   o_io_sw, 32'h0);
      check({tag, "_chg"},  {31'h0, o_sw_changed}, 32'h0);
      check({tag, "_mask"}, o_edge_mask, 32'h0);
   endtask

   // Holds reset over two edges with raw already applied; the next posedge is edge 1.
   task automatic do_reset(logic [31:0] raw);
      i_rst_n  = 1'b0;
      i_sw_raw = raw;
      i_ack    = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      check_zero_outputs("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic step(int n, output int pulses);
      pulses = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk);
         #1;
         i_ack = 1'b0;
         if (o_sw_changed) pulses++;
      end
   endtask

   initial begin
      int pulses;
      i_rst_n  = 1'b0;
      i_sw_raw = '0;
      i_ack    = 1'b0;

      // Clean step on bit 0, then release, then ack.
      vq.push_back(mk(1, 32'h1, 0, 11, 32'h0, 0, 32'h0, 0, "step_e11"));
      vq.push_back(mk(0, 32'h1, 0,  1, 32'h1, 1, 32'h1, 1, "step_e12"));
      vq.push_back(mk(0, 32'h1, 0,  1, 32'h1, 0, 32'h1, 0, "step_e13"));
      vq.push_back(mk(0, 32'h0, 0, 10, 32'h1, 0, 32'h1, 0, "release_e23"));
      vq.push_back(mk(0, 32'h0, 0,  1, 32'h0, 1, 32'h1, 1, "release_e24"));
      vq.push_back(mk(0, 32'h0, 0,  1, 32'h0, 0, 32'h1, 0, "release_e25"));
      vq.push_back(mk(0, 32'h0, 1,  1, 32'h0, 0, 32'h0, 0, "release_ack"));
      // Bit 5 high for 6 cycles: only ticks 4 and 8 see it.
      vq.push_back(mk(1, 32'h0,  0,  1, 32'h0, 0, 32'h0, 0, "glitch_pre"));
      vq.push_back(mk(0, 32'h20, 0,  6, 32'h0, 0, 32'h0, 0, "glitch_high"));
      vq.push_back(mk(0, 32'h0,  0, 13, 32'h0, 0, 32'h0, 0, "glitch_after"));
      // Multi-bit step, ack, ack with nothing pending.
      vq.push_back(mk(1, 32'hA0000003, 0, 11, 32'h0, 0, 32'h0, 0, "multi_e11"));
      vq.push_back(mk(0, 32'hA0000003, 0,  1, 32'hA0000003, 1, 32'hA0000003, 1, "multi_e12"));
      vq.push_back(mk(0, 32'hA0000003, 1,  1, 32'hA0000003, 0, 32'h0, 0, "multi_ack"));
      vq.push_back(mk(0, 32'hA0000003, 1,  1, 32'hA0000003, 0, 32'h0, 0, "multi_ack_idle"));
      // Ack on the same edge bit 2 flips.
      vq.push_back(mk(1, 32'h1, 0, 12, 32'h1, 1, 32'h1, 1, "coinc_b0"));
      vq.push_back(mk(0, 32'h5, 0, 11, 32'h1, 0, 32'h1, 0, "coinc_e23"));
      vq.push_back(mk(0, 32'h5, 1,  1, 32'h5, 1, 32'h4, 1, "coinc_ack_flip"));
      vq.push_back(mk(0, 32'h5, 0,  1, 32'h5, 0, 32'h4, 0, "coinc_after"));

      foreach (vq[n]) begin
         if (vq[n].rst) do_reset(vq[n].raw);
         i_sw_raw = vq[n].raw;
         i_ack    = vq[n].ack;
         step(vq[n].edges, pulses);
         check({vq[n].name, "_io"},     o_io_sw, vq[n].e_io);
         check({vq[n].name, "_chg"},    {31'h0, o_sw_changed}, {31'h0, vq[n].e_chg});
         check({vq[n].name, "_mask"},   o_edge_mask, vq[n].e_mask);
         check({vq[n].name, "_pulses"}, pulses, vq[n].e_pulses);
      end

      // Async reset with outputs high clears them without a clock edge.
      do_reset(32'h1);
      step(12, pulses);
      check("rst_pre_io", o_io_sw, 32'h1);
      i_rst_n = 1'b0;
      #2;
      check_zero_outputs("rst_async");
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Reset mid-count (cnt=2 after edge 8) must discard progress.
      step(8, pulses);
      check("mid_e8_io", o_io_sw, 32'h0);
      i_rst_n = 1'b0;
      #2;
      check_zero_outputs("mid_rst");
      i_rst_n = 1'b1;
      step(11, pulses);
      check("mid_e11_io", o_io_sw, 32'h0);
      check("mid_e11_pulses", pulses, 32'd0);
      step(1, pulses);
      check("mid_e12_io", o_io_sw, 32'h1);
      check("mid_e12_chg", {31'h0, o_sw_changed}, 32'h1);
      check("mid_e12_mask", o_edge_mask, 32'h1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/io_sw_debounce.md
# io_sw_debounce

Input conditioning stage for the board switch bank. It synchronizes the raw, asynchronous switch inputs into the core clock domain and debounces each bit independently. It drives the core's `io_sw_i` input port with clean, stable values. It also records which bits have changed in a sticky edge mask, which software reads and clears through an acknowledge handshake.

## Interface
Parameters:
- WIDTH, 32, number of switch bits.
- TICK_DIV, 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range ≥1.
- STABLE_SAMPLES, 4, consecutive differing samples needed to accept a new level; legal range ≥1.

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sw_raw  in  WIDTH  raw switch pins, asynchronous to i_clk.
- i_ack  in  1  one-cycle pulse that clears the edge mask.
- o_io_sw  out  WIDTH  debounced switch value; feeds the core's io_sw_i.
- o_sw_changed  out  1  single-cycle pulse in the cycle after any o_io_sw bit flips.
- o_edge_mask  out  WIDTH  sticky bitmask of bits that have flipped since the last ack.

## Operation
- **Reset (i_rst_n=0, immediate):** the following are all forced to 0: both synchronizer flop stages, the tick counter, every per-bit count, o_io_sw, o_sw_changed and o_edge_mask.
- **Synchronizer:** two flops per bit, sync1 ← i_sw_raw, then sync2 ← sync1. Only sync2 is used downstream.
- **Tick counter:** counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (counter == TICK_DIV-1), combinational.
  - With TICK_DIV=1, tick is high every cycle.
- **Per-bit debounce,** evaluated only on edges where tick=1:
  - sync2[i] == o_io_sw[i]: cnt[i] ← 0.
  - sync2[i] != o_io_sw[i] and cnt[i]+1 == STABLE_SAMPLES: o_io_sw[i] toggles and cnt[i] ← 0.
  - Otherwise: cnt[i] ← cnt[i]+1.
  - cnt width is clog2(STABLE_SAMPLES+1). The count never exceeds STABLE_SAMPLES-1.
- **Bit independence:** bits are fully independent. Several bits may flip on the same tick.
- **Toggle vector:** flip[i] = 1 when bit i toggles on this edge.
- **o_sw_changed** ← |flip, registered. It is high for exactly one cycle after each flipping edge and 0 otherwise.
- **Edge mask:** o_edge_mask ← (i_ack ? 0 : o_edge_mask) | flip.
  - If ack and a new flip occur on the same edge, the new flip is kept.
- **i_ack with nothing pending:** harmless no-op.

## Timing
- Synchronizer latency is 2 cycles.
- Acceptance latency for a clean step is 2 cycles, plus wait to the next tick (≤TICK_DIV cycles), plus (STABLE_SAMPLES-1)·TICK_DIV cycles.
- A glitch is rejected if it differs from o_io_sw on fewer than STABLE_SAMPLES consecutive ticks. A sample that matches o_io_sw restarts that bit's count.
- Edge numbering: edge 1 is the first rising edge after i_rst_n deasserts.
  - Tick-consuming edges fall at TICK_DIV, 2·TICK_DIV, and so on.
- Reset asserted mid-count discards all progress. After release, debounce restarts from zero state.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Test plan
Bench parameters: WIDTH=32, TICK_DIV=4, STABLE_SAMPLES=3.
- **Clean step:** i_sw_raw=0x1, stable from before edge 1. Ticks fall at edges 4, 8 and 12 → o_io_sw=0x1 after edge 12, o_sw_changed=1 during the following cycle only, o_edge_mask=0x1.
- **Glitch rejection:** bit 5 pulses high for 6 cycles spanning only 1–2 ticks → o_io_sw stays 0x0, o_sw_changed never asserts, o_edge_mask stays 0.
- **Multi-bit and ack:** i_sw_raw steps from 0 to 0xA0000003 → all four bits flip on the same edge, one o_sw_changed pulse, o_edge_mask=0xA0000003. Then a single i_ack pulse → o_edge_mask=0 on the next edge, while o_io_sw holds 0xA0000003.
- **Ack coincident with flip:** mask=0x1 pending; assert i_ack on the same edge that bit 2 flips → o_edge_mask=0x4.
- **Reset mid-operation:** bit 0 is high after 2 ticks (cnt=2); pulse i_rst_n low asynchronously → all outputs 0 immediately. After release, o_io_sw[0] needs the full 3 ticks again (edge 12 relative to release).
- **Release debounce:** o_io_sw=0x1, then i_sw_raw→0 → o_io_sw=0 after 3 ticks, o_sw_changed pulses once, o_edge_mask bit 0 set.
